// File: rtl/sm_nway_pkg.sv
// Shared constants and width helper for the N-way sequencer family.
package sm_nway_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_dwell_cnt.sv
// Dwell counter: counts qualifying enable cycles and flags the step cycle.
module sm_dwell_cnt
    import sm_nway_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cntWidth(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] dcnt_q;
    logic [CW-1:0] dcnt_d;

    assign tick = en && (dcnt_q == LAST);

    // A disabled cycle pauses the count rather than restarting it.
    always_comb begin
        dcnt_d = dcnt_q;
        if (clr) begin
            dcnt_d = '0;
        end else if (tick) begin
            dcnt_d = '0;
        end else if (en) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

endmodule

// File: rtl/sm_nway_seq.sv
// N-state up/down sequencer with per-state dwell, wrap or saturate ends,
// synchronous load and a registered boundary pulse.
module sm_nway_seq
    import sm_nway_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int Y_W        = cntWidth(NUM_STATES),
    parameter int DWELL      = 1,
    parameter bit WRAP       = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           control,
    input  logic           dir,
    input  logic           load,
    input  logic [Y_W-1:0] load_val,
    output logic [Y_W-1:0] y,
    output logic           term
);

    localparam logic [Y_W-1:0] MAX_Y = Y_W'(NUM_STATES - 1);
    localparam logic [Y_W:0]   LIMIT = (Y_W + 1)'(NUM_STATES);

    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;
    logic           term_q;
    logic           term_d;
    logic           step;

    sm_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (control),
        .clr     (load),
        .tick    (step)
    );

    // Load overrides any step on the same edge; ends are detected by explicit
    // compare so non-power-of-two ranges never reach the unused codes.
    always_comb begin
        y_d    = y_q;
        term_d = 1'b0;
        if (load) begin
            y_d = ({1'b0, load_val} >= LIMIT) ? MAX_Y : load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (y_q < MAX_Y) begin
                    y_d = y_q + 1'b1;
                end else begin
                    y_d    = WRAP ? '0 : y_q;
                    term_d = 1'b1;
                end
            end else begin
                if (y_q != '0) begin
                    y_d = y_q - 1'b1;
                end else begin
                    y_d    = WRAP ? MAX_Y : '0;
                    term_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q    <= '0;
            term_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            term_q <= term_d;
        end
    end

    assign y    = y_q;
    assign term = term_q;

endmodule

// File: tb/tb_sm_nway_seq.sv
// Directed bench for sm_nway_seq across four parameter sets.
module tb_sm_nway_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       ctlA = 1'b0, dirA = 1'b0, loadA = 1'b0;
    logic [1:0] lvA = '0, yA;
    logic       termA;

    logic       ctlB = 1'b0, dirB = 1'b0, loadB = 1'b0;
    logic [2:0] lvB = '0, yB;
    logic       termB;

    logic       ctlC = 1'b0, dirC = 1'b0, loadC = 1'b0;
    logic [2:0] lvC = '0, yC;
    logic       termC;

    logic       ctlD = 1'b0, dirD = 1'b0, loadD = 1'b0;
    logic [1:0] lvD = '0, yD;
    logic       termD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_nway_seq dutA (
        .clk(clk), .reset_n(reset_n), .control(ctlA), .dir(dirA),
        .load(loadA), .load_val(lvA), .y(yA), .term(termA)
    );

    sm_nway_seq #(.NUM_STATES(5), .DWELL(3), .WRAP(1'b1)) dutB (
        .clk(clk), .reset_n(reset_n), .control(ctlB), .dir(dirB),
        .load(loadB), .load_val(lvB), .y(yB), .term(termB)
    );

    sm_nway_seq #(.NUM_STATES(6), .DWELL(1), .WRAP(1'b0)) dutC (
        .clk(clk), .reset_n(reset_n), .control(ctlC), .dir(dirC),
        .load(loadC), .load_val(lvC), .y(yC), .term(termC)
    );

    sm_nway_seq #(.NUM_STATES(4), .DWELL(4), .WRAP(1'b1)) dutD (
        .clk(clk), .reset_n(reset_n), .control(ctlD), .dir(dirD),
        .load(loadD), .load_val(lvD), .y(yD), .term(termD)
    );

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expYB[6]    = '{0, 0, 4, 4, 4, 3};
        int expTermB[6] = '{0, 0, 1, 0, 0, 0};
        int expYD[7]    = '{0, 0, 0, 0, 0, 0, 1};
        int ctlSeqD[7]  = '{1, 1, 0, 0, 0, 1, 1};

        // Reset state, then release between edges.
        #12;
        checkOutput("resetA_y", int'(yA), 0);
        checkOutput("resetA_term", int'(termA), 0);
        reset_n = 1'b1;

        // Default config wraps 0,1,2,3,0,1 with term on the return to 0.
        ctlA = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("A_y_%0d", i), int'(yA), i % 4);
            checkOutput($sformatf("A_term_%0d", i), int'(termA), (i == 4) ? 1 : 0);
        end
        ctlA = 1'b0;

        // Five states, dwell 3, counting down from 0 wraps to 4.
        ctlB = 1'b1;
        dirB = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput($sformatf("B_y_%0d", i), int'(yB), expYB[i]);
            checkOutput($sformatf("B_term_%0d", i), int'(termB), expTermB[i]);
        end
        ctlB = 1'b0;

        // Saturating six-state ramp: stops at 5, term on each attempt there.
        ctlC = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("C_y_%0d", i), int'(yC), (i < 5) ? i : 5);
            checkOutput($sformatf("C_term_%0d", i), int'(termC), (i >= 6) ? 1 : 0);
        end

        // Out-of-range load clamps and beats the concurrent step.
        loadC = 1'b1;
        lvC = 3'd7;
        applyStimulus();
        checkOutput("C_loadClamp_y", int'(yC), 5);
        checkOutput("C_loadClamp_term", int'(termC), 0);
        lvC = 3'd2;
        applyStimulus();
        checkOutput("C_load2_y", int'(yC), 2);
        loadC = 1'b0;
        applyStimulus();
        checkOutput("C_afterLoad_y", int'(yC), 3);
        ctlC = 1'b0;

        // Dwell 4 with a pause: only the fourth high cycle steps.
        for (int i = 0; i < 7; i++) begin
            ctlD = ctlSeqD[i][0];
            applyStimulus();
            checkOutput($sformatf("D_y_%0d", i), int'(yD), expYD[i]);
            checkOutput($sformatf("D_term_%0d", i), int'(termD), 0);
        end

        // Run D to y=2, then two cycles into the next dwell.
        ctlD = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("D_reach2_y", int'(yD), 2);
        repeat (2) applyStimulus();
        checkOutput("D_midDwell_y", int'(yD), 2);

        // Asynchronous reset between edges clears immediately.
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("D_asyncReset_y", int'(yD), 0);
        checkOutput("D_asyncReset_term", int'(termD), 0);
        checkOutput("A_asyncReset_y", int'(yA), 0);
        #1;
        reset_n = 1'b1;

        // Dwell restarts from zero: three holds, step on the fourth.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("D_restart_y_%0d", i), int'(yD), (i == 4) ? 1 : 0);
        end
        ctlD = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_nway_seq.md
# sm_nway_seq

Parametrised N-state sequencer: the next generation of the fixed 4-state, 2-bit-output control FSMs. It steps a registered state/output through `NUM_STATES` positions under a `control` enable, and adds:
- up/down direction,
- a per-state dwell count,
- wrap or saturate at the ends,
- synchronous load,
- a boundary pulse.

It is used wherever a small cyclic or ramping control sequence drives downstream muxes or phase selects.

## Interface
Parameters:
- `NUM_STATES`, 4, number of states, legal 2..256.
- `Y_W`, `$clog2(NUM_STATES)`, output width, derived, never overridden.
- `DWELL`, 1, qualifying `control` cycles per step, legal 1..65535.
- `WRAP`, 1, 1 = wrap at ends, 0 = saturate at ends.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `control` in 1: advance enable, sampled each rising edge.
- `dir` in 1: 0 = count up, 1 = count down.
- `load` in 1: synchronous load strobe.
- `load_val` in `Y_W`: value written to `y` on `load`.
- `y` out `Y_W`: current state, registered.
- `term` out 1: one-cycle boundary pulse, registered.

## Operation
- State register: `y` ∈ 0..`NUM_STATES`-1.
- Dwell counter: `dcnt` ∈ 0..`DWELL`-1, width `$clog2(DWELL)` (minimum 1).

Per rising edge, in priority order:
1. `load`=1:
   - `y` ← `load_val`; if `load_val` ≥ `NUM_STATES`, `y` ← `NUM_STATES`-1.
   - `dcnt` ← 0; `term` ← 0.
   - `control` is ignored this cycle.
2. `control`=1 and `dcnt` < `DWELL`-1: `dcnt` ← `dcnt`+1; `y` holds; `term` ← 0.
3. `control`=1 and `dcnt` = `DWELL`-1 ("step"): `dcnt` ← 0, then:
   - Up, `y` < `NUM_STATES`-1: `y` ← `y`+1; `term` ← 0.
   - Up, `y` = `NUM_STATES`-1: `y` ← (`WRAP` ? 0 : `y`); `term` ← 1.
   - Down, `y` > 0: `y` ← `y`-1; `term` ← 0.
   - Down, `y` = 0: `y` ← (`WRAP` ? `NUM_STATES`-1 : 0); `term` ← 1.
4. `control`=0: `y` and `dcnt` hold (pause, not restart); `term` ← 0.

Further rules:
- `dir` changes mid-dwell do not clear `dcnt`. The direction sampled on the step edge governs that step.
- Saturated mode (`WRAP`=0) with `control` held at an end: `term` pulses once every `DWELL` cycles; `y` stays put.
- Non-power-of-two `NUM_STATES`: codes ≥ `NUM_STATES` are unreachable.
- All arithmetic is unsigned at `Y_W` bits. Wrap is by explicit compare, never by natural overflow.

## Timing
- Reset (`reset_n`=0, asynchronous assert): `y`=0, `dcnt`=0, `term`=0 immediately, independent of `clk`.
- Reset release: synchronous to the design; the first edge with `reset_n`=1 evaluates normally.
- Reset mid-dwell or mid-run: all progress is discarded, with no residual `term`.
- Latency: `y`/`term` update on the same edge that samples the qualifying `control`, i.e. visible one cycle after the inputs are presented. No combinational input-to-output path.
- `DWELL`=1 with `control` held: `y` changes every cycle.
- `term` is high for exactly one cycle per boundary step and aligns with the `y` value after the wrap.
- `load` and a step on the same edge: `load` wins and no `term` is produced.

## Structure
- Package `sm_nway_pkg`: `DIR_UP`/`DIR_DOWN` localparams, a width helper function for the `Y_W`/`dcnt` widths.
- Sub-module `sm_dwell_cnt`:
  - Inputs: `clk`, `reset_n`, `en`, `clr`.
  - Output: `tick` (combinational `en && dcnt==DWELL-1`).
  - Parameter: `DWELL`.
- Top level holds the `y`/`term` registers and the next-state logic.

## Test plan
- **Defaults, reset then `control`=1, `dir`=0:** `y` = 0,1,2,3,0,1; `term`=1 only in the cycle `y` returns to 0.
- **`NUM_STATES`=5, `DWELL`=3, `dir`=1, `control`=1 from reset:** `y` stays 0 for 3 cycles → 4 with `term`=1, then 3 after 3 more cycles.
- **`WRAP`=0, `NUM_STATES`=6, up, `control` held 10 cycles:** `y` stops at 5; `term` pulses on each attempted step at 5.
- **`load`=1 with `load_val`=7, `NUM_STATES`=6, while `control`=1:** next `y`=5, `dcnt`=0, `term`=0.
- **`DWELL`=4, `control` high 2 cycles, low 3, high 2:** `y` steps once, on the 4th high cycle.
- **`reset_n` pulsed low between edges mid-dwell at `y`=2:** `y`=0 and `term`=0 immediately; the count restarts from 0 after release.
